parking_capacity_tracker: RTL

Parametrised, clocked successor to the combinational parking occupancy counter. It debounces a vector of raw per-spot sensors and keeps registered counts of parked and empty spots. It also runs an entry-gate request/grant handshake that reserves spots for admitted cars until they park or the reservation times out. It sits between the spot sensor array and the entry gate / display controllers.

---
 rtl/parking_capacity_tracker_pkg.sv | 18 +
 rtl/parking_capacity_tracker_if.sv | 21 ++
 rtl/parking_capacity_tracker_spot_debouncer.sv | 37 +++
 rtl/parking_capacity_tracker.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/parking_capacity_tracker_pkg.sv
// Shared types and constants for the parking capacity tracker.
// Count width helper, entry FSM states and default parameters.
package parking_pkg;

  localparam int DEF_SPOTS    = 8;
  localparam int DEF_DEBOUNCE = 4;
  localparam int DEF_TIMEOUT  = 1024;

  typedef enum logic {
    IDLE,
    HOLD
  } entry_state_t;

  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/parking_capacity_tracker_if.sv
// Entry gate request/grant handshake bundle.
// The gate drives the request, the tracker answers with one pulse.
interface parking_capacity_tracker_if;

  logic entry_req;
  logic entry_grant;
  logic entry_deny;

  modport master (
    output entry_req,
    input  entry_grant,
    input  entry_deny
  );

  modport slave (
    input  entry_req,
    output entry_grant,
    output entry_deny
  );

endinterface

// File: rtl/parking_capacity_tracker_spot_debouncer.sv
// One spot's debouncer: stable bit plus disagreement counter.
// rise flags the edge on which the stable bit goes 0 -> 1.
module spot_debouncer #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic state,
  output logic rise
);

  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DW-1:0] LAST = DW'(DEBOUNCE - 1);

  logic [DW-1:0] cnt;
  logic          flip;

  assign flip = (raw != state) && (cnt == LAST);
  assign rise = flip && raw;

  // count disagreeing cycles, flip once the run is long enough
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= 1'b0;
      cnt   <= '0;
    end else if (raw == state) begin
      cnt <= '0;
    end else if (flip) begin
      state <= ~state;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/parking_capacity_tracker.sv
// Debounced spot occupancy with registered counts and
// an entry gate handshake that reserves spots for admitted cars.
module parking_capacity_tracker
  import parking_pkg::*;
#(
  parameter  int SPOTS    = DEF_SPOTS,
  parameter  int DEBOUNCE = DEF_DEBOUNCE,
  parameter  int TIMEOUT  = DEF_TIMEOUT,
  localparam int CW       = count_width(SPOTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SPOTS-1:0]      spot_raw,
  parking_capacity_tracker_if.slave entry,
  output logic [SPOTS-1:0]      spot_state,
  output logic [CW-1:0]         parked,
  output logic [CW-1:0]         empty,
  output logic [CW-1:0]         pending,
  output logic                  full,
  output logic                  changed
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  function automatic logic [CW-1:0] popcount(
    input logic [SPOTS-1:0] v
  );
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < SPOTS; i++) n += CW'(v[i]);
    return n;
  endfunction

  logic [SPOTS-1:0] rise;
  logic [CW-1:0]    occ;
  logic [CW-1:0]    arr;
  logic [CW:0]      load;

  entry_state_t     state;
  entry_state_t     state_next;
  logic             grant_next;
  logic             deny_next;
  logic             arm;

  logic [TW-1:0]    timer;
  logic [TW-1:0]    timer_next;
  logic [CW-1:0]    pend_next;
  logic             expire;
  int               sum;

  for (genvar i = 0; i < SPOTS; i++) begin : g_spot
    spot_debouncer #(
      .DEBOUNCE (DEBOUNCE)
    ) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (spot_raw[i]),
      .state (spot_state[i]),
      .rise  (rise[i])
    );
  end

  assign occ  = popcount(spot_state);
  assign arr  = popcount(rise);
  assign load = {1'b0, parked} + {1'b0, pending};
  assign full = load >= (CW+1)'(SPOTS);

  // registered counts trail spot_state by one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parked  <= '0;
      empty   <= CW'(SPOTS);
      changed <= 1'b0;
    end else begin
      parked  <= occ;
      empty   <= CW'(SPOTS) - occ;
      changed <= occ != parked;
    end
  end

  // one response per request; arm blocks a request held across reset
  always_comb begin
    state_next = state;
    grant_next = 1'b0;
    deny_next  = 1'b0;
    unique case (state)
      IDLE: begin
        if (entry.entry_req && arm) begin
          state_next = HOLD;
          if (full) deny_next  = 1'b1;
          else      grant_next = 1'b1;
        end
      end
      HOLD: begin
        if (!entry.entry_req) state_next = IDLE;
      end
    endcase
  end

  // FSM state, response pulses and the re-arm flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      entry.entry_grant <= 1'b0;
      entry.entry_deny  <= 1'b0;
      arm               <= 1'b0;
    end else begin
      state             <= state_next;
      entry.entry_grant <= grant_next;
      entry.entry_deny  <= deny_next;
      arm               <= arm | ~entry.entry_req;
    end
  end

  // reservations: grants add, arrivals consume, timeout drops all
  always_comb begin
    expire     = (pending != '0) && (timer == TLAST);
    sum        = int'(pending) + int'(grant_next) - int'(arr);
    pend_next  = pending;
    timer_next = '0;
    if (grant_next && expire) pend_next = CW'(1);
    else if (expire)          pend_next = '0;
    else if (sum < 0)         pend_next = '0;
    else if (sum > SPOTS)     pend_next = CW'(SPOTS);
    else                      pend_next = CW'(sum);
    if (grant_next)           timer_next = '0;
    else if (pending != '0)   timer_next = expire ? '0 : timer + 1'b1;
  end

  // reservation count and idle timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      timer   <= '0;
    end else begin
      pending <= pend_next;
      timer   <= timer_next;
    end
  end

endmodule
